// File: rtl/fft_radix2_sequencer.sv
// In-place radix-2 DIT FFT sequencer: one butterfly every three cycles (READ, WR_A, WR_B)
// over a memory with two combinational read ports and an always-active write port.
module fft_radix2_sequencer #(
  parameter int N     = 32,
  parameter int A_LEN = 5,
  parameter int W     = 16,
  parameter int FRAC  = 14,
  parameter int SCALE = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic [A_LEN-1:0]   raddr1,
  output logic [A_LEN-1:0]   raddr2,
  input  logic [2*W-1:0]     rdata1,
  input  logic [2*W-1:0]     rdata2,
  output logic [A_LEN-1:0]   waddr,
  output logic [2*W-1:0]     wdata,
  output logic [A_LEN-2:0]   tw_addr,
  input  logic [2*W-1:0]     tw_data
);

  localparam int I_W = A_LEN - 1;
  localparam int S_W = (A_LEN > 1) ? $clog2(A_LEN) : 1;
  localparam int SH  = (SCALE != 0) ? 1 : 0;
  localparam logic [S_W-1:0] S_LAST = S_W'(A_LEN - 1);

  typedef enum logic [2:0] {IDLE, READ, WR_A, WR_B, DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [I_W-1:0]   r_i;
  logic [S_W-1:0]   r_s;
  logic [2*W-1:0]   r_sum;
  logic [2*W-1:0]   r_diff;
  logic             r_busy;
  logic             r_done;

  logic [I_W-1:0]   w_mask;
  logic [I_W-1:0]   w_low;
  logic [I_W-1:0]   w_high;
  logic [A_LEN-1:0] w_half;
  logic [A_LEN-1:0] w_a;
  logic [A_LEN-1:0] w_b;
  logic             w_last;

  // (i >> s) << (s+1) equals (i with its low s bits cleared) shifted left once.
  assign w_mask  = ~({I_W{1'b1}} << r_s);
  assign w_low   = r_i & w_mask;
  assign w_high  = r_i & ~w_mask;
  assign w_half  = {{I_W{1'b0}}, 1'b1} << r_s;
  assign w_a     = {w_high, 1'b0} | {1'b0, w_low};
  assign w_b     = w_a | w_half;
  assign tw_addr = w_low << (S_LAST - r_s);
  assign raddr1  = w_a;
  assign raddr2  = w_b;
  assign w_last  = (r_i == {I_W{1'b1}}) && (r_s == S_LAST);

  function automatic logic signed [2*W:0] sx2(input logic signed [W-1:0] v);
    return {{(W+1){v[W-1]}}, v};
  endfunction

  logic signed [W-1:0] w_ar, w_ai, w_br, w_bi, w_wr, w_wi, w_tr, w_ti;
  logic signed [2*W:0] w_pr, w_pi;
  logic signed [W:0]   w_sre, w_sim, w_dre, w_dim;
  logic [W-1:0]        w_sum_re, w_sum_im, w_dif_re, w_dif_im;

  assign w_ar = rdata1[2*W-1:W];
  assign w_ai = rdata1[W-1:0];
  assign w_br = rdata2[2*W-1:W];
  assign w_bi = rdata2[W-1:0];
  assign w_wr = tw_data[2*W-1:W];
  assign w_wi = tw_data[W-1:0];

  assign w_pr = sx2(w_br) * sx2(w_wr) - sx2(w_bi) * sx2(w_wi);
  assign w_pi = sx2(w_br) * sx2(w_wi) + sx2(w_bi) * sx2(w_wr);
  assign w_tr = W'(w_pr >>> FRAC);
  assign w_ti = W'(w_pi >>> FRAC);

  assign w_sre = {w_ar[W-1], w_ar} + {w_tr[W-1], w_tr};
  assign w_sim = {w_ai[W-1], w_ai} + {w_ti[W-1], w_ti};
  assign w_dre = {w_ar[W-1], w_ar} - {w_tr[W-1], w_tr};
  assign w_dim = {w_ai[W-1], w_ai} - {w_ti[W-1], w_ti};

  assign w_sum_re = W'(w_sre >>> SH);
  assign w_sum_im = W'(w_sim >>> SH);
  assign w_dif_re = W'(w_dre >>> SH);
  assign w_dif_im = W'(w_dim >>> SH);

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = READ; else w_next = IDLE;
      READ:    w_next = WR_A;
      WR_A:    w_next = WR_B;
      WR_B:    if (w_last) w_next = DONE; else w_next = READ;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // State, counters, butterfly results and status flags
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_i     <= {I_W{1'b0}};
      r_s     <= {S_W{1'b0}};
      r_sum   <= {(2*W){1'b0}};
      r_diff  <= {(2*W){1'b0}};
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next == READ) || (w_next == WR_A) || (w_next == WR_B);
      r_done  <= (w_next == DONE);
      if (r_state == READ) begin
        r_sum  <= {w_sum_re, w_sum_im};
        r_diff <= {w_dif_re, w_dif_im};
      end
      if (r_state == WR_B) begin
        if (r_i == {I_W{1'b1}}) begin
          r_i <= {I_W{1'b0}};
          r_s <= w_last ? {S_W{1'b0}} : (r_s + {{(S_W-1){1'b0}}, 1'b1});
        end else begin
          r_i <= r_i + {{(I_W-1){1'b0}}, 1'b1};
        end
      end
    end
  end

  // Outside the write states the port rewrites mem[raddr1] with its own contents.
  always_comb begin
    waddr = raddr1;
    wdata = rdata1;
    case (r_state)
      WR_A: begin
        waddr = w_a;
        wdata = r_sum;
      end
      WR_B: begin
        waddr = w_b;
        wdata = r_diff;
      end
      default: begin
        waddr = raddr1;
        wdata = rdata1;
      end
    endcase
  end

  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_fft_radix2_sequencer.sv
// Bench for fft_radix2_sequencer: behavioural sample memory and twiddle ROM,
// result table fed through a scoreboard queue, plus timing and reset sequences.
module tb_fft_radix2_sequencer;
  localparam int N = 32;
  localparam int A_LEN = 5;
  localparam int W = 16;
  localparam real PI = 3.14159265358979323846;

  logic clk = 1'b0;
  logic rst, start, busy, done;
  logic [A_LEN-1:0] raddr1, raddr2, waddr;
  logic [2*W-1:0] rdata1, rdata2, wdata, tw_data;
  logic [A_LEN-2:0] tw_addr;

  logic [2*W-1:0] mem [N];
  logic [2*W-1:0] ld_img [N];
  logic [2*W-1:0] twrom [N/2];
  logic ld_req;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int pat;
    int idx;
    int re;
    int im;
    int tol;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];

  fft_radix2_sequencer #(.N(N), .A_LEN(A_LEN), .W(W), .FRAC(14), .SCALE(1)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1), .rdata2(rdata2),
    .waddr(waddr), .wdata(wdata), .tw_addr(tw_addr), .tw_data(tw_data)
  );

  always #5 clk = ~clk;

  assign rdata1  = mem[raddr1];
  assign rdata2  = mem[raddr2];
  assign tw_data = twrom[tw_addr];

  always @(posedge clk) begin
    if (ld_req) begin
      for (int k = 0; k < N; k++) mem[k] <= ld_img[k];
    end else begin
      mem[waddr] <= wdata;
    end
  end

  function automatic int rnd(real x);
    if (x >= 0.0) return $rtoi(x + 0.5);
    return -$rtoi(-x + 0.5);
  endfunction

  function automatic logic [2*W-1:0] cpx(int re, int im);
    logic [W-1:0] r, i;
    r = re[W-1:0];
    i = im[W-1:0];
    return {r, i};
  endfunction

  task automatic chk(string name, int act, int exp, int tol);
    int d;
    checks++;
    d = act - exp;
    if (d < 0) d = -d;
    if (d > tol) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d tol=%0d", name, act, exp, tol);
    end
  endtask

  task automatic load_pattern(int pat);
    for (int k = 0; k < N; k++) ld_img[k] = '0;
    case (pat)
      0: ld_img[0] = cpx(16384, 0);
      1: for (int k = 0; k < N; k++) ld_img[k] = cpx(16384, 0);
      default: ld_img[16] = cpx(16384, 0);
    endcase
    ld_req = 1'b1;
    @(posedge clk);
    #1 ld_req = 1'b0;
  endtask

  task automatic run_and_check(int pat);
    bit got;
    vec_t v;
    int ar, ai;
    load_pattern(pat);
    foreach (vecs[j]) if (vecs[j].pat == pat) sb.push_back(vecs[j]);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    got = 1'b0;
    for (int n = 0; n < 400 && !got; n++) begin
      @(negedge clk);
      if (done) got = 1'b1;
    end
    chk($sformatf("p%0d_done_seen", pat), int'(got), 1, 0);
    while (sb.size() > 0) begin
      v = sb.pop_front();
      ar = int'($signed(mem[v.idx][2*W-1:W]));
      ai = int'($signed(mem[v.idx][W-1:0]));
      chk($sformatf("p%0d_X%0d_re", pat, v.idx), ar, v.re, v.tol);
      chk($sformatf("p%0d_X%0d_im", pat, v.idx), ai, v.im, v.tol);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int first_busy, busy_cnt, pass_err, b241, b242, b243, d0, d1;
    int b100, b101, dn101, late_done, late_busy;
    int done_times[$];

    for (int k = 0; k < N/2; k++)
      twrom[k] = cpx(rnd(16384.0 * $cos(2.0 * PI * k / N)),
                     rnd(-16384.0 * $sin(2.0 * PI * k / N)));
    for (int k = 0; k < N; k++) begin
      vecs.push_back('{0, k, 512, 0, 0});
      vecs.push_back('{1, k, (k == 0) ? 16384 : 0, 0, 1});
      vecs.push_back('{2, k, rnd(512.0 * $cos(2.0 * PI * k / N)),
                       rnd(-512.0 * $sin(2.0 * PI * k / N)),
                       (k == 0 || k == 8 || k == 16 || k == 24) ? 1 : 2});
    end

    rst = 1'b1; start = 1'b0; ld_req = 1'b0;
    for (int k = 0; k < N; k++) ld_img[k] = '0;
    repeat (3) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_busy", int'(busy), 0, 0);
    chk("reset_done", int'(done), 0, 0);
    chk("reset_raddr1", int'(raddr1), 0, 0);
    chk("reset_raddr2", int'(raddr2), 1, 0);
    chk("reset_tw_addr", int'(tw_addr), 0, 0);
    @(posedge clk);
    #1;

    for (int p = 0; p < 3; p++) run_and_check(p);

    load_pattern(1);
    first_busy = -1; busy_cnt = 0; pass_err = 0; b241 = -1; b242 = -1; b243 = -1;
    start = 1'b1;
    for (int n = 1; n <= 490; n++) begin
      @(posedge clk);
      #1 start = (n == 50 || n == 241 || n == 242);
      @(negedge clk);
      if (busy && first_busy < 0) first_busy = n;
      if (done) done_times.push_back(n);
      if (n <= 242 && busy) busy_cnt++;
      if (n <= 242 && (!busy || (n - 1) % 3 == 0))
        if (waddr != raddr1 || wdata != rdata1) pass_err++;
      if (n == 241) b241 = int'(busy);
      if (n == 242) b242 = int'(busy);
      if (n == 243) b243 = int'(busy);
    end
    start = 1'b0;
    d0 = (done_times.size() > 0) ? done_times[0] : -1;
    d1 = (done_times.size() > 1) ? done_times[1] : -1;
    chk("t_busy_rise", first_busy, 1, 0);
    chk("t_done_count", done_times.size(), 2, 0);
    chk("t_done_first", d0, 241, 0);
    chk("t_done_second", d1, 483, 0);
    chk("t_busy_cycles", busy_cnt, 240, 0);
    chk("t_busy_241", b241, 0, 0);
    chk("t_busy_242", b242, 0, 0);
    chk("t_busy_243", b243, 1, 0);
    chk("t_passthru_errs", pass_err, 0, 0);

    load_pattern(1);
    b100 = -1; b101 = -1; dn101 = -1; late_done = 0; late_busy = 0;
    start = 1'b1;
    for (int n = 1; n <= 300; n++) begin
      @(posedge clk);
      #1 start = 1'b0;
      rst = (n == 100);
      @(negedge clk);
      if (n == 100) b100 = int'(busy);
      if (n == 101) begin
        b101 = int'(busy);
        dn101 = int'(done);
      end
      if (n > 100 && done) late_done++;
      if (n > 100 && busy) late_busy++;
    end
    rst = 1'b0;
    chk("r_busy_100", b100, 1, 0);
    chk("r_busy_101", b101, 0, 0);
    chk("r_done_101", dn101, 0, 0);
    chk("r_no_done_after", late_done, 0, 0);
    chk("r_no_busy_after", late_busy, 0, 0);
    run_and_check(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fft_radix2_sequencer.md
Name: fft_radix2_sequencer

Overview:
- In-place radix-2 decimation-in-time FFT engine for the complex sample memory (two combinational read ports, one always-active write port).
- Drives all memory address and data inputs, consumes both read ports, and fetches twiddles from an external ROM.
- Upstream loads N samples in bit-reversed order and pulses start; on done, the memory holds X[0..N-1] in natural order.

Parameters:
- N, 32, number of points (power of two)
- A_LEN, 5, address width, log2(N)
- W, 16, width of each complex component (signed two's complement)
- FRAC, 14, fractional bits of the samples and twiddles (Q1.14 by default)
- SCALE, 1, 1 = arithmetic shift right by 1 of both butterfly outputs every stage; 0 = no scaling

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  one-cycle pulse; sampled only in IDLE
- busy  output  1  high while the transform runs
- done  output  1  one-cycle pulse when the transform is complete
- raddr1  output  A_LEN  memory read address, top input "a"
- raddr2  output  A_LEN  memory read address, bottom input "b"
- rdata1  input  2*W  mem[raddr1], complex {re[2W-1:W], im[W-1:0]}
- rdata2  input  2*W  mem[raddr2], same format
- waddr  output  A_LEN  memory write address (memory writes every cycle)
- wdata  output  2*W  memory write data
- tw_addr  output  A_LEN-1  twiddle ROM index k
- tw_data  input  2*W  W_N^k = exp(-j*2*pi*k/N), combinational ROM, same format

Behaviour:
- Clocking: one clock, clk. Synchronous active-high reset rst.
- States: IDLE, READ, WR_A, WR_B, DONE.
- Reset: state to IDLE, stage counter s = 0, butterfly counter i = 0, busy = 0, done = 0, result registers = 0.
- Transitions:
  - IDLE -> READ when start = 1; start is ignored in every other state.
  - READ -> WR_A -> WR_B.
  - WR_B -> READ if not on the last butterfly of the last stage; otherwise WR_B -> DONE.
  - DONE -> IDLE.
- Outputs by state: busy = 1 in READ, WR_A and WR_B; done = 1 only in DONE.
- Counters:
  - i runs 0..N/2-1 within each stage; s runs 0..A_LEN-1.
  - i increments on leaving WR_B. On wrap from N/2-1 to 0, s increments.
  - Both counters are zero again when DONE is reached.
- Address generation (half = 2^s):
  - a = ((i >> s) << (s+1)) | (i & (half-1))
  - b = a + half
  - tw_addr = (i & (half-1)) << (A_LEN-1-s)
  - raddr1 = a and raddr2 = b in all states; tw_addr is held valid in READ.
- READ cycle:
  - t = rdata2 * tw_data as a complex product.
  - re_t = (br*wr - bi*wi) >>> FRAC; im_t = (br*wi + bi*wr) >>> FRAC. Products are full 2W precision; the result is truncated to W bits.
  - sum = rdata1 + t and diff = rdata1 - t, computed at W+1 bits.
  - If SCALE = 1, both are shifted right arithmetically by 1. The results are then truncated (wrapped) to W bits.
  - sum and diff are registered at the end of READ.
- Writes:
  - WR_A: waddr = a, wdata = sum register.
  - WR_B: waddr = b, wdata = diff register.
  - IDLE, READ, DONE: waddr = raddr1 and wdata = rdata1. This rewrites the same value, so the memory is never corrupted.
- Latency: start seen in IDLE at cycle 0 -> READ at cycle 1.
  - Each butterfly takes 3 cycles; there are (N/2)*A_LEN butterflies.
  - done is high at cycle 1 + 3*(N/2)*A_LEN, which is cycle 241 for N = 32; busy is high for 240 cycles.
  - The block returns to IDLE the following cycle, and a new start is accepted there.
- Overflow: no saturation; two's-complement wrap. With SCALE = 1 the final output equals X[k]/N.
- Reset mid-operation: IDLE next cycle, busy = 0, no done pulse. Memory contents are partial and are not restored.
- start asserted while rst is high: ignored.

Test Plan:
- Impulse: mem[0] = {16384, 0}, all other words zero, SCALE = 1, start -> all 32 words = {512, 0} at done.
- DC: all 32 words = {16384, 0} -> word 0 = {16384, 0}, words 1..31 = {0, 0} within ±1 LSB.
- Shifted impulse: x[1] = 1.0, loaded at bit-reversed address 16 -> X[8] = {0, -512} and X[0] = {512, 0}, each within ±1 LSB.
- Timing: start at cycle 0 -> busy rises at cycle 1, done pulses exactly at cycle 241 for one cycle, busy low from cycle 241.
  - Check waddr/wdata equal raddr1/rdata1 on every IDLE and READ cycle.
- start pulsed at cycles 50 and 241 -> both ignored, a single done pulse only; a start at cycle 242 begins a new run.
- rst asserted at cycle 100 -> cycle 101: busy = 0, done = 0, state IDLE. A reload of the DC input plus start then reproduces the DC result.
